// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair. The result is formed at issue
// into shadow registers and committed to HI/LO after a fixed busy latency.
module mdu_iterative #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [5:0]       r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic [WIDTH-1:0] r_res_hi, w_res_hi_nxt;
    logic [WIDTH-1:0] r_res_lo, w_res_lo_nxt;
    logic             r_skip, w_skip_nxt;

    logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_b_safe;
    logic [WIDTH-1:0]   w_q_mag, w_r_mag, w_quo, w_rem;

    // Signed product is the low 2*WIDTH bits of the sign-extended operands.
    assign w_mul_a = (op == OP_MULT) ? {{WIDTH{srcA[WIDTH-1]}}, srcA} : {{WIDTH{1'b0}}, srcA};
    assign w_mul_b = (op == OP_MULT) ? {{WIDTH{srcB[WIDTH-1]}}, srcB} : {{WIDTH{1'b0}}, srcB};
    assign w_prod  = w_mul_a * w_mul_b;

    // Divide on magnitudes so MIN / -1 wraps naturally to MIN with remainder 0.
    assign w_a_neg  = (op == OP_DIV) && srcA[WIDTH-1];
    assign w_b_neg  = (op == OP_DIV) && srcB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~srcA + 1'b1) : srcA;
    assign w_b_mag  = w_b_neg ? (~srcB + 1'b1) : srcB;
    assign w_b_safe = (srcB == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quo    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_rem    = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_res_hi_nxt = r_res_hi;
        w_res_lo_nxt = r_res_lo;
        w_skip_nxt   = r_skip;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_res_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
                            w_res_lo_nxt = w_prod[WIDTH-1:0];
                            w_skip_nxt   = 1'b0;
                            w_cnt_nxt    = 6'(MULT_CYCLES);
                            w_state_nxt  = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_res_hi_nxt = w_rem;
                            w_res_lo_nxt = w_quo;
                            w_skip_nxt   = (srcB == '0);
                            w_cnt_nxt    = 6'(DIV_CYCLES);
                            w_state_nxt  = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = srcA;
                        OP_MTLO: w_lo_nxt = srcA;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_cnt == 6'd1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (!r_skip) begin
                        w_hi_nxt = r_res_hi;
                        w_lo_nxt = r_res_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_skip   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_res_lo <= w_res_lo_nxt;
            r_skip   <= w_skip_nxt;
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed corner cases plus randomized ops checked against
// an arithmetic HI/LO model.
module tb_mdu_iterative;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] srcA, srcB;
    logic         busy;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]   m_hi, m_lo;
    logic [2*W-1:0] exp_q[$];

    mdu_iterative #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural HI/LO pair.
    task automatic model_apply(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int cyc);
        longint      sa, sb, q, r;
        logic [63:0] p, qv, rv;
        cyc = 0;
        case (o)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
                cyc  = MC;
            end
            OP_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                cyc  = MC;
            end
            OP_DIV: begin
                if (b != 0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    qv = 64'(q);
                    rv = 64'(r);
                    m_lo = qv[31:0];
                    m_hi = rv[31:0];
                end
                cyc = DC;
            end
            OP_DIVU: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                cyc = DC;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where busy has dropped.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int             cyc, cnt;
        logic [W-1:0]   prev_hi, prev_lo;
        logic [2*W-1:0] e;
        prev_hi = m_hi;
        prev_lo = m_lo;
        model_apply(o, a, b, cyc);
        exp_q.push_back({m_hi, m_lo});
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
        srcA = $urandom;
        srcB = $urandom;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            if (cnt == 0) begin
                check({tag, "/hi_hold"}, hi, prev_hi);
                check({tag, "/lo_hold"}, lo, prev_lo);
            end
            cnt++;
            @(negedge clk);
        end
        check({tag, "/busy_cycles"}, cnt, cyc);
        e = exp_q.pop_front();
        check({tag, "/hi"}, hi, e[2*W-1:W]);
        check({tag, "/lo"}, lo, e[W-1:0]);
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          cyc, cnt;
        logic [3:0]  ro;
        reset = 1'b0; start = 1'b0; op = '0; srcA = '0; srcB = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/hi", hi, 0);
        check("reset/lo", lo, 0);
        check("reset/busy", busy, 0);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle/busy", busy, 0);
            check("idle/hi", hi, 0);
            check("idle/lo", lo, 0);
        end

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg");
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min");
        run_op(OP_MTHI,  32'h1234, 32'd0, "mthi");
        run_op(OP_MTLO,  32'h5678, 32'd0, "mtlo");
        run_op(OP_DIVU,  32'd7, 32'd0, "divu_zero");
        run_op(OP_DIV,   32'd100, 32'd0, "div_zero");
        run_op(4'b1111,  32'hAAAA, 32'h5555, "undef_op");

        // Starts issued while busy must be ignored.
        model_apply(OP_MULT, 32'd3, 32'd4, cyc);
        start = 1'b1; op = OP_MULT; srcA = 32'd3; srcB = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("ign/busy1", busy, 1);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; srcA = 32'd9; srcB = 32'd3;
        @(negedge clk);
        op = OP_MTLO; srcA = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        cnt = 3;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("ign/busy_cycles", cnt, MC);
        check("ign/hi", hi, m_hi);
        check("ign/lo", lo, m_lo);
        check("ign/lo_value", lo, 32'd12);

        // Reset during an operation discards the result.
        start = 1'b1; op = OP_MULT; srcA = 32'd5; srcB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid/busy3", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid/busy", busy, 0);
        check("rst_mid/hi", hi, 0);
        check("rst_mid/lo", lo, 0);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (8) begin
            @(negedge clk);
            check("rst_mid/no_commit_lo", lo, 0);
            check("rst_mid/no_busy", busy, 0);
        end

        // Randomized traffic, issued back-to-back.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0: ro = OP_MULT;
                1: ro = OP_MULTU;
                2: ro = OP_DIV;
                3: ro = OP_DIVU;
                4: ro = OP_MTHI;
                5: ro = OP_MTLO;
                6: ro = 4'b0000;
                default: ro = 4'($urandom_range(7, 15));
            endcase
            run_op(ro, rand_val(), rand_val(), $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
